// File: rtl/audio_pkg.sv
// Shared types and tables for the audio playback sequencer.
// The note table holds half periods in clock cycles; zero entries are silent.
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } audio_state_t;

    localparam int NOTE_MSB = 13;
    localparam int NOTE_LSB = 8;
    localparam int DUR_MSB  = 7;
    localparam int DUR_LSB  = 0;

    localparam logic [15:0] NOTE_HP [0:63] = '{
        16'd12, 16'd11, 16'd10, 16'd9,  16'd8,  16'd7,  16'd7,  16'd6,
        16'd6,  16'd5,  16'd5,  16'd5,  16'd4,  16'd4,  16'd4,  16'd4,
        16'd3,  16'd3,  16'd3,  16'd3,  16'd3,  16'd3,  16'd2,  16'd2,
        16'd2,  16'd2,  16'd2,  16'd2,  16'd2,  16'd2,  16'd2,  16'd2,
        16'd1,  16'd1,  16'd1,  16'd1,  16'd1,  16'd1,  16'd1,  16'd1,
        16'd1,  16'd1,  16'd1,  16'd1,  16'd1,  16'd1,  16'd1,  16'd1,
        16'd20, 16'd24, 16'd28, 16'd32, 16'd40, 16'd48, 16'd56, 16'd64,
        16'd0,  16'd0,  16'd0,  16'd0,  16'd0,  16'd0,  16'd0,  16'd0
    };

endpackage

// File: rtl/audio_seq_tone_gen.sv
// Square-wave generator: half-period counter plus speaker flip-flop.
// Counter and output clear whenever disabled or the half period is zero.
module tone_gen #(
    parameter int HP_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [HP_W-1:0] hp,
    output logic            speaker
);

    logic [HP_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || !en || hp == '0) begin
            cnt     <= '0;
            speaker <= 1'b0;
        end else if (cnt == hp - HP_W'(1)) begin
            cnt     <= '0;
            speaker <= ~speaker;
        end else begin
            cnt <= cnt + HP_W'(1);
        end
    end

endmodule

// File: rtl/audio_seq.sv
// Audio playback sequencer: latches note/duration, plays a square wave, stalls the CPU until done.
// Optional AUDIO_REST_EN: note index 0 becomes a silent rest of the programmed duration.
module audio_seq
    import audio_pkg::*;
#(
    parameter int TICK_CYCLES = 24000,
    parameter int HP_W        = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        audioreg,
    input  logic        audioact,
    input  logic [15:0] data_in,
    output logic        continue_o,
    output logic        busy,
    output logic        speaker
);

    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

    audio_state_t    state, state_next;
    logic [5:0]      note_r, play_note;
    logic [7:0]      dur_r, play_dur;
    logic [TICK_W-1:0] tick;
    logic            tick_wrap;
    logic            tone_en;
    logic [HP_W-1:0] hp;
    logic            unused_bits;

    assign unused_bits = ^data_in[15:14];
    assign tick_wrap   = (tick == TICK_LAST);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (audioact) state_next = (dur_r == 8'd0) ? DONE : PLAY;
            PLAY: begin
                if (!audioact)
                    state_next = IDLE;
                else if (tick_wrap && play_dur == 8'd1)
                    state_next = DONE;
            end
            DONE: if (!audioact) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            continue_o <= 1'b0;
            note_r     <= '0;
            dur_r      <= '0;
            play_note  <= '0;
            play_dur   <= '0;
            tick       <= '0;
        end else begin
            state      <= state_next;
            busy       <= (state_next == PLAY);
            continue_o <= (state_next == DONE);
            if (audioreg) begin
                note_r <= data_in[NOTE_MSB:NOTE_LSB];
                dur_r  <= data_in[DUR_MSB:DUR_LSB];
            end
            // Snapshot uses the pre-load registers, so a same-edge load affects the next play only
            if (state == IDLE && audioact) begin
                play_note <= note_r;
                play_dur  <= dur_r;
                tick      <= '0;
            end else if (state == PLAY) begin
                if (tick_wrap) begin
                    tick     <= '0;
                    play_dur <= play_dur - 8'd1;
                end else begin
                    tick <= tick + TICK_W'(1);
                end
            end else begin
                tick <= '0;
            end
        end
    end

    // Run only while staying in PLAY so speaker is already 0 on the edge that leaves it
    assign tone_en = (state == PLAY) && (state_next == PLAY);

`ifdef AUDIO_REST_EN
    assign hp = (play_note == 6'd0) ? '0 : HP_W'(NOTE_HP[play_note]);
`else
    assign hp = HP_W'(NOTE_HP[play_note]);
`endif

    tone_gen #(.HP_W(HP_W)) u_tone (
        .clk     (clk),
        .reset   (reset),
        .en      (tone_en),
        .hp      (hp),
        .speaker (speaker)
    );

endmodule
